// File: rtl/spi_master.sv
// SPI EEPROM master, mode 0, 3-wire bus (sdo/sdoe/sdi).
// Frame: command byte (0x02 write / 0x03 read), 24-bit address, data, MSB first.
// Optional feature macro: SPI_MASTER_BURST_EN (sequential-address bursts in HOLD).
module spi_master #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic                  sck,
   output logic                  cs_n,
   output logic                  sdo,
   output logic                  sdoe,
   input  logic                  sdi
);

   localparam int              SW     = 32 + DATA_WIDTH;
   localparam logic [8:0]      DIV_M1 = 9'(CLK_DIV - 1);
   localparam logic [8:0]      GAP_M1 = 9'(2 * CLK_DIV - 1);
   localparam logic [15:0]     DW_M1  = 16'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, TURN, DATA, HOLD, GAP} state_t;

   state_t                  state, nxt;
   logic [8:0]              divc;
   logic [15:0]             bitc;
   logic                    sck_q;
   logic                    wr;
   logic [SW-1:0]           sh;
   logic [DATA_WIDTH-1:0]   rx;
   logic                    shifting, wrap, rise, fall, burst_ok, rsp_evt;

   // Bit states toggle sck every CLK_DIV cycles; GAP runs for two half-periods.
   assign shifting = (state == CMD) || (state == ADDR) || (state == TURN) || (state == DATA);
   assign wrap     = (state == GAP) ? (divc == GAP_M1) : (divc == DIV_M1);
   assign rise     = shifting && wrap && !sck_q;
   assign fall     = shifting && wrap && sck_q;
   assign sck      = sck_q;
   assign sdo      = sh[SW-1];

`ifdef SPI_MASTER_BURST_EN
   logic [ADDR_WIDTH-1:0] addr, addr_inc;
   assign addr_inc = addr + 1'b1;
   // A same-type command at the next address continues the open frame.
   assign burst_ok = (state == HOLD) && cmd_valid && (cmd_write == wr) && (cmd_addr == addr_inc);
   // Each burst byte reports at the falling edge that ends its last bit.
   assign rsp_evt  = (state == DATA) && (nxt == HOLD) && !wr;
`else
   assign burst_ok = 1'b0;
   // Read data is reported on the edge that raises cs_n.
   assign rsp_evt  = (state == HOLD) && (nxt == GAP) && !wr;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state and bus control outputs.
   always_comb begin
      nxt       = state;
      cmd_ready = 1'b0;
      busy      = (state != IDLE);
      cs_n      = (state == IDLE) || (state == GAP);
      sdoe      = (state == SETUP) || (state == CMD) || (state == ADDR) ||
                  (wr && ((state == DATA) || (state == HOLD)));
      case (state)
         IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid && !rst) nxt = SETUP;
         end
         SETUP: if (wrap) nxt = CMD;
         CMD:   if (fall && bitc == 16'd7)  nxt = ADDR;
         ADDR:  if (fall && bitc == 16'd23) nxt = wr ? DATA : TURN;
         TURN:  if (fall) nxt = DATA;
         DATA:  if (fall && bitc == DW_M1) nxt = HOLD;
         HOLD: begin
            cmd_ready = !rst && burst_ok;
            if (burst_ok)  nxt = DATA;
            else if (wrap) nxt = GAP;
         end
         GAP:   if (wrap) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Timing counters, shift registers, command latch and read response.
   always_ff @(posedge clk) begin
      if (rst) begin
         divc      <= '0;
         bitc      <= '0;
         sck_q     <= 1'b0;
         wr        <= 1'b0;
         sh        <= '0;
         rx        <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef SPI_MASTER_BURST_EN
         addr      <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         divc      <= (wrap || nxt != state) ? 9'd0 : divc + 1'b1;
         if (nxt != state) bitc <= '0;
         else if (fall)    bitc <= bitc + 1'b1;
         if (shifting && wrap) sck_q <= !sck_q;
         if (state == IDLE && nxt == SETUP) begin
            wr <= cmd_write;
            sh <= {(cmd_write ? 8'h02 : 8'h03), 24'(cmd_addr),
                   (cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}})};
`ifdef SPI_MASTER_BURST_EN
            addr <= cmd_addr;
         end else if (state == HOLD && nxt == DATA) begin
            sh   <= {(cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}}), 32'h0};
            addr <= addr_inc;
`endif
         end else if (fall) begin
            sh <= {sh[SW-2:0], 1'b0};
         end
         if (rise && state == DATA && !wr) rx <= {rx[DATA_WIDTH-2:0], sdi};
         if (rsp_evt) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rx;
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV 2, one at CLK_DIV 1,
// a bus monitor per instance and a simple EEPROM-side responder on sdi.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cv [2], cw [2], cr [2], rspv [2], bz [2];
   logic        sck [2], csn [2], sdo [2], sdoe [2], sdi [2];
   logic [17:0] ca [2];
   logic [7:0]  cd [2], rd [2];

   spi_master #(.CLK_DIV(2)) u_dut0 (
      .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(cr[0]), .cmd_write(cw[0]),
      .cmd_addr(ca[0]), .cmd_wdata(cd[0]), .rsp_valid(rspv[0]), .rsp_rdata(rd[0]),
      .busy(bz[0]), .sck(sck[0]), .cs_n(csn[0]), .sdo(sdo[0]), .sdoe(sdoe[0]), .sdi(sdi[0]));

   spi_master #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(cr[1]), .cmd_write(cw[1]),
      .cmd_addr(ca[1]), .cmd_wdata(cd[1]), .rsp_valid(rspv[1]), .rsp_rdata(rd[1]),
      .busy(bz[1]), .sck(sck[1]), .cs_n(csn[1]), .sdo(sdo[1]), .sdoe(sdoe[1]), .sdi(sdi[1]));

   int          n_tests = 0, n_fail = 0, cyc = 0;
   int          rcnt [2], cslow [2], gap_cur [2], gap_min [2], rsp_cnt [2];
   int          per_min [2], per_max [2], last_rise [2], frames [2], rdy_busy [2], rsp_bad [2];
   logic [63:0] cap [2];
   logic [31:0] hdr [2];
   logic        oe_hdr [2], oe_r32 [2], oe_data [2], p_cs [2], p_sck [2];
   logic [7:0]  rsp_data [2], sl_data [2];

   always @(posedge clk) cyc <= cyc + 1;

   // Responder: data bits follow header (32) and turnaround (1); bursts repeat the byte.
   assign sdi[0] = (!csn[0] && rcnt[0] >= 33) ? sl_data[0][3'(7 - ((rcnt[0] - 33) % 8))] : 1'b0;
   assign sdi[1] = (!csn[1] && rcnt[1] >= 33) ? sl_data[1][3'(7 - ((rcnt[1] - 33) % 8))] : 1'b0;

   // Bus monitor, sampled on the falling clk edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!csn[i]) begin
            if (p_cs[i]) begin
               frames[i]++; rcnt[i] = 0; cslow[i] = 0; cap[i] = '0; hdr[i] = '0;
               oe_hdr[i] = 1'b1; oe_r32[i] = 1'b1; oe_data[i] = 1'b1;
               per_min[i] = 999; per_max[i] = 0;
               if (gap_cur[i] < gap_min[i]) gap_min[i] = gap_cur[i];
            end
            gap_cur[i] = 0;
            cslow[i]++;
         end else begin
            gap_cur[i]++;
         end
         if (sck[i] && !p_sck[i]) begin
            if (rcnt[i] > 0) begin
               if (cyc - last_rise[i] < per_min[i]) per_min[i] = cyc - last_rise[i];
               if (cyc - last_rise[i] > per_max[i]) per_max[i] = cyc - last_rise[i];
            end
            last_rise[i] = cyc;
            cap[i] = {cap[i][62:0], sdo[i]};
            if (rcnt[i] < 32) begin
               hdr[i] = {hdr[i][30:0], sdo[i]};
               oe_hdr[i] = oe_hdr[i] & sdoe[i];
            end else begin
               oe_data[i] = oe_data[i] & sdoe[i];
            end
            if (rcnt[i] == 32) oe_r32[i] = sdoe[i];
            rcnt[i]++;
         end
         if (rspv[i]) begin
            rsp_cnt[i]++;
            rsp_data[i] = rd[i];
            if (!(csn[i] && !p_cs[i])) rsp_bad[i]++;
         end
         if (bz[i] && cr[i]) rdy_busy[i]++;
         p_cs[i]  = csn[i];
         p_sck[i] = sck[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait for the cycle where cmd_ready is high, let the handshake edge pass.
   task automatic hs(input int i);
      int t = 0;
      #1;
      while (!cr[i] && t < 3000) begin @(negedge clk); #1; t++; end
      if (t >= 3000) chk("handshake_timeout", 64'(t), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic send(input int i, input logic w, input logic [17:0] a, input logic [7:0] d);
      @(negedge clk);
      cv[i] = 1'b1; cw[i] = w; ca[i] = a; cd[i] = d;
      hs(i);
      cv[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int t = 0;
      while (bz[i] && t < 6000) begin @(negedge clk); #1; t++; end
      chk("idle_timeout", 64'(t < 6000), 64'd1);
   endtask

   int r0, f0, t;

   initial begin
      for (int i = 0; i < 2; i++) begin
         cv[i] = 0; cw[i] = 0; ca[i] = '0; cd[i] = '0; sl_data[i] = '0;
         rcnt[i] = 0; cslow[i] = 0; gap_cur[i] = 0; gap_min[i] = 999; rsp_cnt[i] = 0;
         per_min[i] = 999; per_max[i] = 0; last_rise[i] = 0; frames[i] = 0;
         rdy_busy[i] = 0; rsp_bad[i] = 0; cap[i] = '0; hdr[i] = '0;
         oe_hdr[i] = 1; oe_r32[i] = 1; oe_data[i] = 1; p_cs[i] = 1; p_sck[i] = 0;
         rsp_data[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_outs", {57'd0, csn[0], sck[0], sdo[0], sdoe[0], rspv[0], bz[0], cr[0]}, 64'b1000000);
      chk("rst_rdata", 64'(rd[0]), 64'd0);
      rst = 1'b0;
      #1 chk("ready_after_rst", 64'(cr[0]), 64'd1);

      // Write 0x12345 / 0xA5
      send(0, 1'b1, 18'h12345, 8'hA5);
      wait_idle(0);
      chk("wr_bits", cap[0][39:0], 64'h02_012345_A5);
      chk("wr_nbits", 64'(rcnt[0]), 64'd40);
      chk("wr_sdoe", 64'(oe_hdr[0] & oe_data[0]), 64'd1);
      chk("wr_cs_low", 64'(cslow[0]), 64'd164);
      chk("wr_sck_per", {per_min[0], per_max[0]}, {32'd4, 32'd4});

      // Read 0x00010, responder returns 0x5A
      sl_data[0] = 8'h5A;
      r0 = rsp_cnt[0];
      send(0, 1'b0, 18'h00010, 8'h00);
      wait_idle(0);
      chk("rd_hdr", 64'(hdr[0]), 64'h03000010);
      chk("rd_sdoe_hdr", 64'(oe_hdr[0]), 64'd1);
      chk("rd_sdoe_turn", 64'(oe_r32[0]), 64'd0);
      chk("rd_nbits", 64'(rcnt[0]), 64'd41);
      chk("rd_rsp_cnt", 64'(rsp_cnt[0] - r0), 64'd1);
      chk("rd_rsp_data", 64'(rsp_data[0]), 64'h5A);
      chk("rd_cs_low", 64'(cslow[0]), 64'd168);
`ifndef SPI_MASTER_BURST_EN
      chk("rd_rsp_at_cs", 64'(rsp_bad[0]), 64'd0);
`endif

      // Back-to-back writes with cmd_valid held
      gap_min[0] = 999; f0 = frames[0]; rdy_busy[0] = 0;
      @(negedge clk);
      cv[0] = 1; cw[0] = 1; ca[0] = 18'h00100; cd[0] = 8'h11;
      hs(0);
      ca[0] = 18'h00300; cd[0] = 8'h22;
      hs(0);
      cv[0] = 0;
      wait_idle(0);
      chk("b2b_frames", 64'(frames[0] - f0), 64'd2);
      chk("b2b_gap_ge4", 64'(gap_min[0] >= 4), 64'd1);
      chk("b2b_bits", cap[0][39:0], 64'h02_000300_22);
`ifndef SPI_MASTER_BURST_EN
      chk("b2b_ready_busy", 64'(rdy_busy[0]), 64'd0);
`endif
      chk("rdata_held", 64'(rd[0]), 64'h5A);

      // Reset abort during address bit 10 of a read
      r0 = rsp_cnt[0];
      send(0, 1'b0, 18'h00020, 8'h00);
      t = 0;
      while (rcnt[0] < 19 && t < 3000) begin @(negedge clk); #1; t++; end
      chk("abort_reach", 64'(t < 3000), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_outs", {60'd0, csn[0], sck[0], sdoe[0], bz[0]}, 64'b1000);
      chk("abort_ready_in_rst", 64'(cr[0]), 64'd0);
      @(negedge clk); rst = 1'b0;
      #1 chk("abort_ready_after", 64'(cr[0]), 64'd1);
      send(0, 1'b1, 18'h00777, 8'h3C);
      wait_idle(0);
      chk("abort_no_rsp", 64'(rsp_cnt[0] - r0), 64'd0);
      chk("abort_new_cmd", cap[0][39:0], 64'h02_000777_3C);

      // CLK_DIV 1 instance
      send(1, 1'b1, 18'h3FFFF, 8'hFF);
      wait_idle(1);
      chk("div1_bits", cap[1][39:0], 64'h02_03FFFF_FF);
      chk("div1_nbits", 64'(rcnt[1]), 64'd40);
      chk("div1_sck_per", {per_min[1], per_max[1]}, {32'd2, 32'd2});
      chk("div1_cs_low", 64'(cslow[1]), 64'd82);

`ifdef SPI_MASTER_BURST_EN
      // Sequential reads share one frame; a jump closes it
      sl_data[0] = 8'hC3; r0 = rsp_cnt[0]; f0 = frames[0];
      @(negedge clk);
      cv[0] = 1; cw[0] = 0; ca[0] = 18'h00100;
      hs(0);
      ca[0] = 18'h00101;
      hs(0);
      ca[0] = 18'h00200;
      t = 0;
      while (!csn[0] && t < 3000) begin @(negedge clk); #1; t++; end
      chk("burst_frames", 64'(frames[0] - f0), 64'd1);
      chk("burst_hdr", 64'(hdr[0]), 64'h03000100);
      chk("burst_nbits", 64'(rcnt[0]), 64'd49);
      chk("burst_rsp_cnt", 64'(rsp_cnt[0] - r0), 64'd2);
      chk("burst_rsp_data", 64'(rsp_data[0]), 64'hC3);
      hs(0);
      cv[0] = 0;
      wait_idle(0);
      chk("burst_close", 64'(frames[0] - f0), 64'd2);
      chk("burst_new_hdr", 64'(hdr[0]), 64'h03000200);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
